instr_prefetch_buffer: RTL and testbench

- Sits between the core instruction port and the instruction memory/bus.
- Keeps a small FIFO of sequentially prefetched, word-aligned instruction words, each tagged with its address.
- Core requests that hit the FIFO head are served without a memory round trip.
- Misses and flushes redirect the prefetch stream to the new address.

---
 rtl/instr_prefetch_buffer.sv | 148 ++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
`timescale 1ns/1ps
// Instruction prefetch buffer: a small FIFO of sequential, word-aligned fetches
// tagged with their address; head hits answer locally, empty-FIFO misses bypass the returning word.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_flush_i,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_rsp_o,
  output logic [31:0] core_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [29:0] tag;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DROP} mstate_e;

  mstate_e            state_q, state_d;
  entry_t [DEPTH-1:0] fifo_q;
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [29:0]        fptr_q, fptr_d, maddr_q, maddr_d;
  logic               mreq_q, mreq_d, rsp_q, rsp_d;
  logic [31:0]        rdata_q, rdata_d;

  logic   eval, hit, bypass, miss, push, pop, ack_busy;
  entry_t head;
  logic   unused_addr_lsb;

  assign unused_addr_lsb = ^core_addr_i[1:0];

  always_comb begin
    head     = fifo_q[rd_q];
    eval     = core_req_i && !rsp_q && !core_flush_i;
    ack_busy = (state_q == M_BUSY) && mem_ack_i;
    hit      = eval && (cnt_q != '0) && (head.tag == core_addr_i[31:2]);
    bypass   = eval && (cnt_q == '0) && ack_busy && (maddr_q == core_addr_i[31:2]);
    miss     = eval && !hit && !bypass;
    pop      = hit;
    // The in-flight slot is reserved at issue time, so the full guard is only a backstop.
    push     = ack_busy && !core_flush_i && !miss && !bypass && (cnt_q != FULL);
  end

  always_comb begin
    state_d = state_q;
    mreq_d  = mreq_q;
    maddr_d = maddr_q;
    fptr_d  = fptr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;

    if (hit) begin
      rsp_d   = 1'b1;
      rdata_d = head.data;
    end else if (bypass) begin
      rsp_d   = 1'b1;
      rdata_d = mem_data_i;
    end

    if (core_flush_i || miss) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    if (miss) fptr_d = core_addr_i[31:2];

    unique case (state_q)
      M_IDLE: begin
        // Issue from the post-update pointer/count so a redirect goes out immediately.
        if (!core_flush_i && (cnt_d < FULL)) begin
          state_d = M_BUSY;
          mreq_d  = 1'b1;
          maddr_d = fptr_d;
        end
      end
      M_BUSY: begin
        if (mem_ack_i) begin
          state_d = M_IDLE;
          mreq_d  = 1'b0;
          if (!core_flush_i && !miss) fptr_d = fptr_q + 30'd1;
        end else if (core_flush_i || (miss && (core_addr_i[31:2] != maddr_q))) begin
          state_d = M_DROP;
        end
      end
      M_DROP: begin
        if (mem_ack_i) begin
          state_d = M_IDLE;
          mreq_d  = 1'b0;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      mreq_q  <= 1'b0;
      maddr_q <= BOOT_ADDRESS[31:2];
      fptr_q  <= BOOT_ADDRESS[31:2];
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
      fptr_q  <= fptr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_q[wr_q] <= '{tag: maddr_q, data: mem_data_i};
  end

  assign core_rsp_o  = rsp_q;
  assign core_data_o = rdata_q;
  assign mem_req_o   = mreq_q;
  assign mem_addr_o  = {maddr_q, 2'b00};

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
`timescale 1ns/1ps
// Directed bench for instr_prefetch_buffer; memory returns addr+0x13 for each word,
// either from an automatic 2-cycle responder or from acks driven by the main sequence.
module tb_instr_prefetch_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_flush = 1'b0;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_rsp;
  logic [31:0] core_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  logic        auto_mem = 1'b1;
  logic        a_ack = 1'b0, m_ack = 1'b0;
  logic [31:0] a_data = '0, m_data = '0;
  logic        rsp_prev = 1'b0, req_prev = 1'b0;
  int          checks = 0, errors = 0, rcnt = 0, issues = 0, consec = 0, issues0 = 0;

  assign mem_ack  = auto_mem ? a_ack  : m_ack;
  assign mem_data = auto_mem ? a_data : m_data;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .BOOT_ADDRESS(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .core_flush_i(core_flush), .core_req_i(core_req),
    .core_addr_i(core_addr), .core_rsp_o(core_rsp), .core_data_o(core_data),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data)
  );

  // Automatic memory: ack on the second cycle a request is seen.
  initial forever begin
    @(negedge clk);
    a_ack = 1'b0;
    if (!auto_mem || !mem_req) rcnt = 0;
    else begin
      rcnt++;
      if (rcnt == 2) begin
        a_ack  = 1'b1;
        a_data = mem_addr + 32'h13;
        rcnt   = 0;
      end
    end
  end

  // Response pulses must never be back to back; count request issues.
  initial forever begin
    @(negedge clk);
    if (core_rsp && rsp_prev) consec++;
    if (mem_req && !req_prev) issues++;
    rsp_prev = core_rsp;
    req_prev = mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                       input int exp_lat);
    int lat;
    lat = 0;
    core_req  = 1'b1;
    core_addr = a;
    do begin
      @(negedge clk);
      lat++;
    end while (!core_rsp && lat < 40);
    core_req = 1'b0;
    chk({tag, "_rsp"}, 32'(core_rsp), 32'd1);
    chk({tag, "_data"}, core_data, exp_d);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
  endtask

  task automatic wait_issue(input string tag, input logic [31:0] exp_a);
    int n;
    n = 0;
    while (!mem_req && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_a);
    n = 0;
    while (mem_req && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin
    tick(3);
    chk("rst_rsp", 32'(core_rsp), 32'd0);
    chk("rst_data", core_data, 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);

    // Cold start: bypass of word 0, then sequential refill until four entries are held.
    rst_n = 1'b1;
    fetch("boot", 32'h0, 32'h13, 3);
    wait_issue("pf4", 32'h4);
    wait_issue("pf8", 32'h8);
    wait_issue("pfC", 32'hC);
    wait_issue("pf10", 32'h10);
    tick(10);
    chk("full_stop", 32'(mem_req), 32'd0);

    // Sequential hits from a full buffer; each pop refills exactly one word.
    issues0 = issues;
    fetch("hit4", 32'h4, 32'h17, 1);
    fetch("hit8", 32'h8, 32'h1B, 1);
    fetch("hitC", 32'hC, 32'h1F, 1);
    tick(15);
    chk("refills", issues - issues0, 32'd3);
    chk("refill_stop", 32'(mem_req), 32'd0);

    // Redirect while a prefetch of 0x20 is outstanding.
    auto_mem = 1'b0;
    fetch("hit10", 32'h10, 32'h23, 1);
    chk("inflight_req", 32'(mem_req), 32'd1);
    chk("inflight_addr", mem_addr, 32'h20);
    core_req  = 1'b1;
    core_addr = 32'h100;
    @(negedge clk);
    chk("drop_rsp", 32'(core_rsp), 32'd0);
    chk("drop_req", 32'(mem_req), 32'd1);
    chk("drop_addr", mem_addr, 32'h20);
    m_ack  = 1'b1;
    m_data = 32'h33;
    @(negedge clk);
    m_ack = 1'b0;
    chk("dropped_rsp", 32'(core_rsp), 32'd0);
    chk("dropped_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h100);
    m_ack  = 1'b1;
    m_data = 32'h113;
    @(negedge clk);
    m_ack    = 1'b0;
    core_req = 1'b0;
    chk("bypass_rsp", 32'(core_rsp), 32'd1);
    chk("bypass_data", core_data, 32'h113);
    @(negedge clk);
    chk("next_req", 32'(mem_req), 32'd1);
    chk("next_addr", mem_addr, 32'h104);

    // Flush in the same cycle as the ack: data discarded, pointer not advanced.
    m_ack      = 1'b1;
    m_data     = 32'h117;
    core_flush = 1'b1;
    @(negedge clk);
    m_ack      = 1'b0;
    core_flush = 1'b0;
    chk("flush_req", 32'(mem_req), 32'd0);
    chk("flush_rsp", 32'(core_rsp), 32'd0);
    @(negedge clk);
    chk("flush_rsp2", 32'(core_rsp), 32'd0);
    chk("reissue_req", 32'(mem_req), 32'd1);
    chk("reissue_addr", mem_addr, 32'h104);
    auto_mem = 1'b1;
    tick(15);

    // Halfword-aligned request fetches the containing word.
    core_req  = 1'b1;
    core_addr = 32'h6;
    @(negedge clk);
    chk("half_req", 32'(mem_req), 32'd1);
    chk("half_addr", mem_addr, 32'h4);
    fetch("half", 32'h6, 32'h17, 0);

    // Reset during an outstanding read; the late ack must be ignored.
    auto_mem = 1'b0;
    begin
      int n;
      n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
    end
    chk("pre_rst_busy", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_req", 32'(mem_req), 32'd0);
    chk("rst2_addr", mem_addr, 32'h0);
    chk("rst2_rsp", 32'(core_rsp), 32'd0);
    chk("rst2_data", core_data, 32'h0);
    rst_n  = 1'b1;
    m_ack  = 1'b1;
    m_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("boot_req", 32'(mem_req), 32'd1);
    chk("boot_addr", mem_addr, 32'h0);
    m_data = 32'h13;
    @(negedge clk);
    m_ack = 1'b0;
    fetch("post_rst", 32'h0, 32'h13, 1);

    // Pointer wrap from the top word back to zero.
    auto_mem = 1'b1;
    fetch("top", 32'hFFFF_FFFC, 32'h0000_000F, 0);
    chk("wrap_req", 32'(mem_req), 32'd1);
    chk("wrap_addr", mem_addr, 32'h0);

    chk("no_b2b_rsp", consec, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
